// File: rtl/vec_mem_arbiter_pkg.sv
// Shared types and default geometry for the vector memory datapath.
// The state encoding is visible here so that other pipeline modules can decode it.
package vec_mem_pkg;

    localparam int DEF_I = 32;
    localparam int DEF_N = 8;
    localparam int DEF_R = 6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P_ISSUE = 3'd1,
        P_LAST  = 3'd2,
        P_DONE  = 3'd3,
        H_ACC   = 3'd4,
        H_RESP  = 3'd5
    } arb_state_t;

    // Width of a lane index; at least one bit even for a single-lane vector.
    function automatic int lane_idx_w(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/vec_mem_arbiter_if.sv
// Bus bundle for the arbiter: MEM-stage vector port, host byte port and byte RAM port.
// slave is the arbiter's view, master is the surrounding environment's view.
interface vec_mem_arbiter_if
    import vec_mem_pkg::*;
#(
    parameter int I = DEF_I,
    parameter int N = DEF_N,
    parameter int R = DEF_R
);

    logic           MemReqM;
    logic           MemWriteM;
    logic [I-1:0]   AddressM;
    logic [R*N-1:0] WriteDataM;
    logic [R*N-1:0] ReadDataM;
    logic           StallM;

    logic           host_req;
    logic           host_we;
    logic [I-1:0]   host_addr;
    logic [N-1:0]   host_wdata;
    logic           host_gnt;
    logic           host_valid;
    logic [N-1:0]   host_rdata;

    logic           mem_we;
    logic [I-1:0]   mem_addr;
    logic [N-1:0]   mem_wd;
    logic [N-1:0]   mem_rd;

    modport slave (
        input  MemReqM, MemWriteM, AddressM, WriteDataM,
        output ReadDataM, StallM,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_valid, host_rdata,
        output mem_we, mem_addr, mem_wd,
        input  mem_rd
    );

    modport master (
        output MemReqM, MemWriteM, AddressM, WriteDataM,
        input  ReadDataM, StallM,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_valid, host_rdata,
        input  mem_we, mem_addr, mem_wd,
        output mem_rd
    );

endinterface

// File: rtl/vec_mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is the vector pipeline, bit 1 the host.
// Grants only while i_en is high; the priority bit then points at the loser.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    logic r_prio;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt    = 2'b00;
        w_gnt[0] = i_en & i_req[0] & (~i_req[1] | ~r_prio);
        w_gnt[1] = i_en & i_req[1] & (~i_req[0] |  r_prio);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (w_gnt[0]) begin
            r_prio <= 1'b1;
        end else if (w_gnt[1]) begin
            r_prio <= 1'b0;
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/vec_mem_arbiter.sv
// Serialises R-lane vector loads/stores onto a byte-wide synchronous RAM and
// interleaves single-byte host accesses between vector transactions.
module vec_mem_arbiter
    import vec_mem_pkg::*;
#(
    parameter int I = DEF_I,
    parameter int N = DEF_N,
    parameter int R = DEF_R
)(
    input  logic             clk,
    input  logic             reset,
    vec_mem_arbiter_if.slave bus
);

    localparam int              K_W    = lane_idx_w(R);
    localparam logic [K_W-1:0]  K_LAST = K_W'(R - 1);

    arb_state_t     r_state;
    arb_state_t     w_state_next;
    logic [K_W-1:0] r_k;
    logic           r_we;
    logic [I-1:0]   r_base;
    logic           r_h_we;
    logic [I-1:0]   r_h_addr;
    logic [N-1:0]   r_h_wd;

    logic [1:0]     w_gnt;
    logic           w_arb_en;
    logic           w_mem_we;
    logic [I-1:0]   w_mem_addr;
    logic [N-1:0]   w_mem_wd;
    logic           w_host_gnt;
    logic           w_host_valid;
    logic           w_cap_en;
    logic [K_W-1:0] w_cap_idx;
    logic [N-1:0]   w_wdata [R];

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (reset),
        .i_req ({bus.host_req, bus.MemReqM}),
        .i_en  (w_arb_en),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_state_next = r_state;
        w_arb_en     = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_mem_wd     = '0;
        w_host_gnt   = 1'b0;
        w_host_valid = 1'b0;
        w_cap_en     = 1'b0;
        w_cap_idx    = '0;
        case (r_state)
            IDLE: begin
                w_arb_en = 1'b1;
                if (w_gnt[0]) begin
                    w_state_next = P_ISSUE;
                end else if (w_gnt[1]) begin
                    w_state_next = H_ACC;
                end
            end
            P_ISSUE: begin
                w_mem_addr = r_base + I'(r_k);
                w_mem_we   = r_we;
                w_mem_wd   = w_wdata[r_k];
                // Read data lags the address by one cycle, so lane k-1 lands now.
                if (!r_we && (r_k != '0)) begin
                    w_cap_en  = 1'b1;
                    w_cap_idx = r_k - K_W'(1);
                end
                if (r_k == K_LAST) begin
                    w_state_next = r_we ? P_DONE : P_LAST;
                end
            end
            P_LAST: begin
                w_cap_en     = 1'b1;
                w_cap_idx    = K_LAST;
                w_state_next = P_DONE;
            end
            P_DONE: begin
                w_state_next = IDLE;
            end
            H_ACC: begin
                w_host_gnt   = 1'b1;
                w_mem_addr   = r_h_addr;
                w_mem_we     = r_h_we;
                w_mem_wd     = r_h_wd;
                w_state_next = H_RESP;
            end
            H_RESP: begin
                w_host_valid = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_we     <= 1'b0;
            r_base   <= '0;
            r_h_we   <= 1'b0;
            r_h_addr <= '0;
            r_h_wd   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_gnt[0]) begin
                r_we   <= bus.MemWriteM;
                r_base <= bus.AddressM;
                r_k    <= '0;
            end else if (r_state == P_ISSUE) begin
                r_k <= (r_k == K_LAST) ? '0 : r_k + K_W'(1);
            end
            if (w_gnt[1]) begin
                r_h_we   <= bus.host_we;
                r_h_addr <= bus.host_addr;
                r_h_wd   <= bus.host_wdata;
            end
        end
    end

    for (genvar gi = 0; gi < R; gi++) begin : g_lane
        logic [N-1:0] r_wd;
        logic [N-1:0] r_rd;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_wd <= '0;
                r_rd <= '0;
            end else begin
                if (w_gnt[0]) begin
                    r_wd <= bus.WriteDataM[gi*N +: N];
                end
                if (w_cap_en && (w_cap_idx == K_W'(gi))) begin
                    r_rd <= bus.mem_rd;
                end
            end
        end

        assign w_wdata[gi]              = r_wd;
        assign bus.ReadDataM[gi*N +: N] = r_rd;
    end

    assign bus.StallM     = bus.MemReqM & (r_state != P_DONE);
    assign bus.host_gnt   = w_host_gnt;
    assign bus.host_valid = w_host_valid;
    assign bus.host_rdata = (r_state == H_RESP) ? bus.mem_rd : '0;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wd     = w_mem_wd;

endmodule
